// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush generation for the 5-stage core. Resolves
// hazards that forwarding cannot cover, holds the pipeline on data-memory
// waits, applies trap/redirect flushes, drops wrong-path fetches, flags
// data-memory timeouts and counts IF stall cycles.

package hazard_pkg;
  typedef enum logic [1:0] {
    NO_TYPE = 2'd0,
    TYPE1   = 2'd1,
    TYPE2   = 2'd2,
    TYPE3   = 2'd3
  } forwarding_type_t;
endpackage

module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT     = 64,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [4:0]                 rs1_id,
  input  logic [4:0]                 rs2_id,
  input  logic                       rs1_used_id,
  input  logic                       rs2_used_id,
  input  forwarding_type_t           forwarding_type_id,
  input  logic [4:0]                 rd_ex,
  input  logic                       reg_we_ex,
  input  logic                       mem_rd_en_ex,
  input  logic                       zicsr_ex,
  input  logic [4:0]                 rd_mem,
  input  logic                       mem_rd_en_mem,
  input  logic                       pc_redirect_id,
  input  logic                       trap_mem,
  input  logic                       fetch_busy,
  input  logic                       fetch_valid,
  input  logic                       data_mem_req_mem,
  input  logic                       data_mem_ack_mem,
  output logic                       stall_if,
  output logic                       stall_id,
  output logic                       stall_ex,
  output logic                       stall_mem,
  output logic                       flush_id,
  output logic                       flush_ex,
  output logic                       flush_mem,
  output logic                       bubble_wb,
  output logic                       discard_fetch,
  output logic                       mem_timeout,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [STALL_CNT_WIDTH-1:0] STALL_SAT = {STALL_CNT_WIDTH{1'b1}};

  logic                       need1_s, need2_s;
  logic                       m1_ex_s, m2_ex_s, m1_mem_s, m2_mem_s;
  logic                       is_type2_s;
  logic                       load_use_s, type2_ex_s, type2_mem_s;
  logic                       id_hazard_s;
  logic                       mem_wait_s;
  logic                       redirect_eff_s;
  logic                       discard_pending_r;
  logic [WAIT_W-1:0]          wait_cnt_r;
  logic [STALL_CNT_WIDTH-1:0] stall_cycles_r;

  assign need1_s    = rs1_used_id && (forwarding_type_id != NO_TYPE);
  assign need2_s    = rs2_used_id && (forwarding_type_id != NO_TYPE);
  assign m1_ex_s    = (rs1_id == rd_ex) && (rd_ex != 5'd0) && reg_we_ex;
  assign m2_ex_s    = (rs2_id == rd_ex) && (rd_ex != 5'd0) && reg_we_ex;
  assign m1_mem_s   = (rs1_id == rd_mem) && (rd_mem != 5'd0);
  assign m2_mem_s   = (rs2_id == rd_mem) && (rd_mem != 5'd0);
  assign is_type2_s = (forwarding_type_id == TYPE2);

  // Load result is not available until after MEM: always a one-cycle stall.
  assign load_use_s  = ((need1_s && m1_ex_s) || (need2_s && m2_ex_s)) && mem_rd_en_ex;
  // Type2 consumers need the operand in ID; a Zicsr result on rs1 is routed directly.
  assign type2_ex_s  = is_type2_s && !mem_rd_en_ex &&
                       ((need1_s && m1_ex_s && !zicsr_ex) || (need2_s && m2_ex_s));
  assign type2_mem_s = is_type2_s && mem_rd_en_mem &&
                       ((need1_s && m1_mem_s) || (need2_s && m2_mem_s));
  assign id_hazard_s = load_use_s || type2_ex_s || type2_mem_s;

  assign mem_wait_s  = data_mem_req_mem && !data_mem_ack_mem;

  // Prioritised stall/flush decode; a memory wait freezes everything.
  always_comb begin
    stall_if       = 1'b0;
    stall_id       = 1'b0;
    stall_ex       = 1'b0;
    stall_mem      = 1'b0;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    flush_mem      = 1'b0;
    bubble_wb      = 1'b0;
    redirect_eff_s = 1'b0;
    if (mem_wait_s) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      bubble_wb = 1'b1;
    end else if (trap_mem) begin
      flush_id       = 1'b1;
      flush_ex       = 1'b1;
      flush_mem      = 1'b1;
      redirect_eff_s = 1'b1;
    end else if (id_hazard_s) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end else if (pc_redirect_id) begin
      flush_id       = 1'b1;
      redirect_eff_s = 1'b1;
    end else begin
      redirect_eff_s = 1'b0;
    end
  end

  assign discard_fetch = discard_pending_r && fetch_valid;
  assign mem_timeout   = mem_wait_s && (wait_cnt_r == WAIT_LAST);
  assign stall_cycles  = stall_cycles_r;

  // Remember a redirect while the old fetch is still in flight; new redirect wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      discard_pending_r <= 1'b0;
    end else if (redirect_eff_s && fetch_busy) begin
      discard_pending_r <= 1'b1;
    end else if (fetch_valid) begin
      discard_pending_r <= 1'b0;
    end
  end

  // Count consecutive wait cycles, parking at the limit so the timeout fires once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else if (!mem_wait_s) begin
      wait_cnt_r <= '0;
    end else if (wait_cnt_r != WAIT_MAX) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end
  end

  // Saturating count of cycles with IF held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles_r <= '0;
    end else if (stall_if && (stall_cycles_r != STALL_SAT)) begin
      stall_cycles_r <= stall_cycles_r + STALL_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit (MEM_TIMEOUT=4, STALL_CNT_WIDTH=4).
module tb_hazard_unit;
  import hazard_pkg::*;

  logic clock, reset;
  logic [4:0] rs1_id, rs2_id, rd_ex, rd_mem;
  logic rs1_used_id, rs2_used_id;
  forwarding_type_t forwarding_type_id;
  logic reg_we_ex, mem_rd_en_ex, zicsr_ex, mem_rd_en_mem;
  logic pc_redirect_id, trap_mem, fetch_busy, fetch_valid;
  logic data_mem_req_mem, data_mem_ack_mem;
  logic stall_if, stall_id, stall_ex, stall_mem;
  logic flush_id, flush_ex, flush_mem, bubble_wb, discard_fetch, mem_timeout;
  logic [3:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  // Output vector order: stall_if stall_id stall_ex stall_mem flush_id flush_ex flush_mem bubble_wb discard_fetch mem_timeout
  localparam logic [9:0] O_NONE  = 10'b0000000000;
  localparam logic [9:0] O_HAZ   = 10'b1100010000;
  localparam logic [9:0] O_WAIT  = 10'b1111000100;
  localparam logic [9:0] O_TRAP  = 10'b0000111000;
  localparam logic [9:0] O_REDIR = 10'b0000100000;
  localparam logic [9:0] O_DISC  = 10'b0000000010;
  localparam logic [9:0] O_TO    = 10'b0000000001;

  hazard_unit #(.MEM_TIMEOUT(4), .STALL_CNT_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .forwarding_type_id(forwarding_type_id),
    .rd_ex(rd_ex), .reg_we_ex(reg_we_ex), .mem_rd_en_ex(mem_rd_en_ex), .zicsr_ex(zicsr_ex),
    .rd_mem(rd_mem), .mem_rd_en_mem(mem_rd_en_mem),
    .pc_redirect_id(pc_redirect_id), .trap_mem(trap_mem),
    .fetch_busy(fetch_busy), .fetch_valid(fetch_valid),
    .data_mem_req_mem(data_mem_req_mem), .data_mem_ack_mem(data_mem_ack_mem),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
    .bubble_wb(bubble_wb), .discard_fetch(discard_fetch),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [9:0] outs();
    return {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
            flush_mem, bubble_wb, discard_fetch, mem_timeout};
  endfunction

  task automatic idle();
    rs1_id = 5'd0; rs2_id = 5'd0; rs1_used_id = 1'b0; rs2_used_id = 1'b0;
    forwarding_type_id = NO_TYPE;
    rd_ex = 5'd0; reg_we_ex = 1'b0; mem_rd_en_ex = 1'b0; zicsr_ex = 1'b0;
    rd_mem = 5'd0; mem_rd_en_mem = 1'b0;
    pc_redirect_id = 1'b0; trap_mem = 1'b0; fetch_busy = 1'b0; fetch_valid = 1'b0;
    data_mem_req_mem = 1'b0; data_mem_ack_mem = 1'b0;
  endtask

  // Advance to one time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (outs() !== O_NONE) begin
      bad++; $display("FAIL reset_outs actual=%b required=%b", outs(), O_NONE);
    end
    total++;
    if (stall_cycles !== 4'd0) begin
      bad++; $display("FAIL reset_cnt actual=%0d required=0", stall_cycles);
    end
    next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_load_use();
    idle();
    rs1_id = 5'd5; rs1_used_id = 1'b1; forwarding_type_id = TYPE1;
    rd_ex = 5'd5; reg_we_ex = 1'b1; mem_rd_en_ex = 1'b1;
    @(negedge clock);
    total++;
    if (outs() !== O_HAZ) begin
      bad++; $display("FAIL load_use actual=%b required=%b", outs(), O_HAZ);
    end
    next_cycle();
    // load moved to MEM, bubble in EX: Type1 consumer proceeds
    rd_ex = 5'd0; reg_we_ex = 1'b0; mem_rd_en_ex = 1'b0;
    rd_mem = 5'd5; mem_rd_en_mem = 1'b1;
    @(negedge clock);
    total++;
    if (outs() !== O_NONE) begin
      bad++; $display("FAIL load_use_release actual=%b required=%b", outs(), O_NONE);
    end
    next_cycle();
    idle();
    rs1_id = 5'd0; rs1_used_id = 1'b1; forwarding_type_id = TYPE1;
    rd_ex = 5'd0; reg_we_ex = 1'b1; mem_rd_en_ex = 1'b1;
    @(negedge clock);
    total++;
    if (outs() !== O_NONE) begin
      bad++; $display("FAIL load_use_x0 actual=%b required=%b", outs(), O_NONE);
    end
    next_cycle();
    idle();
    rs2_id = 5'd9; rs2_used_id = 1'b1; forwarding_type_id = NO_TYPE;
    rd_ex = 5'd9; reg_we_ex = 1'b1; mem_rd_en_ex = 1'b1;
    @(negedge clock);
    total++;
    if (outs() !== O_NONE) begin
      bad++; $display("FAIL load_use_notype actual=%b required=%b", outs(), O_NONE);
    end
    next_cycle();
  endtask

  task automatic test_type2();
    idle();
    rs2_id = 5'd7; rs2_used_id = 1'b1; forwarding_type_id = TYPE2;
    rd_ex = 5'd7; reg_we_ex = 1'b1;
    @(negedge clock);
    total++;
    if (outs() !== O_HAZ) begin
      bad++; $display("FAIL type2_ex_rs2 actual=%b required=%b", outs(), O_HAZ);
    end
    next_cycle();
    idle();
    rs1_id = 5'd7; rs1_used_id = 1'b1; forwarding_type_id = TYPE2;
    rd_ex = 5'd7; reg_we_ex = 1'b1; zicsr_ex = 1'b1;
    @(negedge clock);
    total++;
    if (outs() !== O_NONE) begin
      bad++; $display("FAIL type2_zicsr actual=%b required=%b", outs(), O_NONE);
    end
    next_cycle();
    idle();
    rs1_id = 5'd7; rs1_used_id = 1'b1; forwarding_type_id = TYPE2;
    rd_ex = 5'd3; reg_we_ex = 1'b1; rd_mem = 5'd7; mem_rd_en_mem = 1'b1;
    @(negedge clock);
    total++;
    if (outs() !== O_HAZ) begin
      bad++; $display("FAIL type2_mem_load actual=%b required=%b", outs(), O_HAZ);
    end
    next_cycle();
    // same consumer once the MEM-stage producer is not a load
    mem_rd_en_mem = 1'b0;
    @(negedge clock);
    total++;
    if (outs() !== O_NONE) begin
      bad++; $display("FAIL type2_mem_alu actual=%b required=%b", outs(), O_NONE);
    end
    next_cycle();
  endtask

  task automatic test_mem_wait();
    idle();
    data_mem_req_mem = 1'b1; trap_mem = 1'b1; pc_redirect_id = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      total++;
      if (outs() !== O_WAIT) begin
        bad++; $display("FAIL mem_wait_c%0d actual=%b required=%b", i, outs(), O_WAIT);
      end
      next_cycle();
    end
    data_mem_ack_mem = 1'b1;
    @(negedge clock);
    total++;
    if (outs() !== O_TRAP) begin
      bad++; $display("FAIL mem_wait_ack actual=%b required=%b", outs(), O_TRAP);
    end
    next_cycle();
  endtask

  task automatic test_discard();
    idle();
    pc_redirect_id = 1'b1; fetch_busy = 1'b1;
    @(negedge clock);
    total++;
    if (outs() !== O_REDIR) begin
      bad++; $display("FAIL discard_redirect actual=%b required=%b", outs(), O_REDIR);
    end
    next_cycle();
    pc_redirect_id = 1'b0;
    @(negedge clock);
    total++;
    if (outs() !== O_NONE) begin
      bad++; $display("FAIL discard_busy actual=%b required=%b", outs(), O_NONE);
    end
    next_cycle();
    fetch_busy = 1'b0; fetch_valid = 1'b1;
    @(negedge clock);
    total++;
    if (outs() !== O_DISC) begin
      bad++; $display("FAIL discard_drop actual=%b required=%b", outs(), O_DISC);
    end
    next_cycle();
    @(negedge clock);
    total++;
    if (outs() !== O_NONE) begin
      bad++; $display("FAIL discard_next actual=%b required=%b", outs(), O_NONE);
    end
    next_cycle();
    // redirect masked by a memory wait must not arm a discard
    idle();
    data_mem_req_mem = 1'b1; pc_redirect_id = 1'b1; fetch_busy = 1'b1;
    next_cycle();
    idle();
    fetch_valid = 1'b1;
    @(negedge clock);
    total++;
    if (outs() !== O_NONE) begin
      bad++; $display("FAIL discard_masked actual=%b required=%b", outs(), O_NONE);
    end
    next_cycle();
    // trap arms a discard; reset clears it
    idle();
    trap_mem = 1'b1; fetch_busy = 1'b1;
    next_cycle();
    idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    fetch_valid = 1'b1;
    @(negedge clock);
    total++;
    if (outs() !== O_NONE) begin
      bad++; $display("FAIL discard_reset actual=%b required=%b", outs(), O_NONE);
    end
    next_cycle();
    idle();
  endtask

  task automatic test_timeout();
    logic [9:0] exp;
    idle();
    next_cycle();
    data_mem_req_mem = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp = (i == 3) ? (O_WAIT | O_TO) : O_WAIT;
      @(negedge clock);
      total++;
      if (outs() !== exp) begin
        bad++; $display("FAIL timeout_c%0d actual=%b required=%b", i, outs(), exp);
      end
      next_cycle();
    end
    idle();
    next_cycle();
    data_mem_req_mem = 1'b1;
    next_cycle();
    next_cycle();
    // two wait cycles counted; asynchronous reset mid-cycle
    reset = 1'b1;
    #1;
    total++;
    if (stall_cycles !== 4'd0) begin
      bad++; $display("FAIL timeout_reset_cnt actual=%0d required=0", stall_cycles);
    end
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp = (i == 3) ? (O_WAIT | O_TO) : O_WAIT;
      @(negedge clock);
      total++;
      if (outs() !== exp) begin
        bad++; $display("FAIL timeout_after_reset_c%0d actual=%b required=%b", i, outs(), exp);
      end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_counter();
    int exp_cnt;
    do_reset();
    rs1_id = 5'd5; rs1_used_id = 1'b1; forwarding_type_id = TYPE1;
    rd_ex = 5'd5; reg_we_ex = 1'b1; mem_rd_en_ex = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      exp_cnt = (i > 15) ? 15 : i;
      @(negedge clock);
      total++;
      if (stall_cycles !== 4'(exp_cnt)) begin
        bad++; $display("FAIL stall_cnt_c%0d actual=%0d required=%0d", i, stall_cycles, exp_cnt);
      end
      next_cycle();
    end
    idle();
    @(negedge clock);
    total++;
    if (stall_cycles !== 4'd15) begin
      bad++; $display("FAIL stall_cnt_hold actual=%0d required=15", stall_cycles);
    end
    next_cycle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    next_cycle();
    test_reset();
    test_load_use();
    test_type2();
    test_mem_wait();
    test_discard();
    test_timeout();
    test_counter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline control block for the 5-stage core; sits directly downstream of `forwarding_unit` and consumes the same ID/EX/MEM register tags plus the decode-stage forwarding type. It covers the hazards that forwarding cannot resolve, producing per-stage stall/flush controls from those hazards, data-memory wait handshakes and PC redirects/traps. Sequential state:
- discard of in-flight wrong-path fetches
- data-memory wait timeout counter
- saturating stall-cycle performance counter

## Interface
- `MEM_TIMEOUT`, 64: consecutive data-memory wait cycles before `mem_timeout` pulses (≥2).
- `STALL_CNT_WIDTH`, 16: width of `stall_cycles`.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `rs1_id`, `rs2_id`  in  5  source registers in ID.
- `rs1_used_id`, `rs2_used_id`  in  1  ID instruction actually reads the source.
- `forwarding_type_id`  in  `forwarding_type_t`  NoType/Type1/Type2/Type3 of the ID instruction.
- `rd_ex`  in  5  destination register in EX.
- `reg_we_ex`  in  1  EX instruction writes `rd_ex`.
- `mem_rd_en_ex`  in  1  EX instruction is a load.
- `zicsr_ex`  in  1  EX instruction is Zicsr.
- `rd_mem`  in  5  destination register in MEM.
- `mem_rd_en_mem`  in  1  MEM instruction is a load.
- `pc_redirect_id`  in  1  branch/jump taken, resolved in ID.
- `trap_mem`  in  1  exception/interrupt taken at MEM.
- `fetch_busy`  in  1  instruction-memory request in flight, not returning this cycle.
- `fetch_valid`  in  1  instruction memory returns an instruction this cycle.
- `data_mem_req_mem`  in  1  MEM stage data access active.
- `data_mem_ack_mem`  in  1  data access completes this cycle.
- `stall_if`, `stall_id`, `stall_ex`, `stall_mem`  out  1  hold the corresponding pipeline register.
- `flush_id`, `flush_ex`, `flush_mem`  out  1  load a bubble into the corresponding pipeline register.
- `bubble_wb`  out  1  MEM/WB register receives a bubble.
- `discard_fetch`  out  1  IF drops the returning instruction.
- `mem_timeout`  out  1  one-cycle pulse: data access exceeded `MEM_TIMEOUT`.
- `stall_cycles`  out  `STALL_CNT_WIDTH`  saturating count of cycles with `stall_if`=1.

## Operation

**Derived terms**
- `match(rs,rd,en)` = `rs==rd && rd!=0 && en`.
- `need_k` = `rsk_used_id && forwarding_type_id!=NoType`.
- `mem_wait` = `data_mem_req_mem && !data_mem_ack_mem`.

**`id_hazard` (OR of)**
- Load-use: `need_k && match(rsk_id,rd_ex,reg_we_ex) && mem_rd_en_ex`, k∈{1,2}.
- Type2 EX producer: `forwarding_type_id==Type2 && need_k && match(rsk_id,rd_ex,reg_we_ex) && !mem_rd_en_ex`, except k=1 with `zicsr_ex`=1 (ID can take that EX result directly).
- Type2 load in MEM: `forwarding_type_id==Type2 && need_k && match(rsk_id,rd_mem,1) && mem_rd_en_mem`.

**Priority (first match wins; unlisted outputs 0)**
1. `mem_wait`: all four stalls=1, `bubble_wb`=1. Redirect and trap are ignored; their sources are held by the stall and re-present.
2. `trap_mem`: `flush_id`=`flush_ex`=`flush_mem`=1.
3. `id_hazard`: `stall_if`=`stall_id`=1, `flush_ex`=1.
4. `pc_redirect_id`: `flush_id`=1.

**Discard register**
- `redirect_eff` = case 2 or case 4 active this cycle.
- Set `discard_pending` when `redirect_eff && fetch_busy`.
- Clear it on `fetch_valid`.
- `discard_fetch` = `discard_pending && fetch_valid`.
- Set and clear in the same cycle (`fetch_valid` with a new `redirect_eff && fetch_busy`): set wins. `fetch_busy` and `fetch_valid` are never both 1.

**Wait counter**
- `wait_cnt`, width $clog2(MEM_TIMEOUT+1).
- `mem_wait`=1: increments, stopping at `MEM_TIMEOUT`.
- `mem_wait`=0: returns to 0.
- `mem_timeout` = `mem_wait && wait_cnt==MEM_TIMEOUT-1`. Exactly one pulse per access, with no repeat if the wait continues.

**Stall counter**
- `stall_cycles` increments when `stall_if`=1.
- Saturates at all-ones.

## Timing
- All control outputs are combinational from the current inputs and registered state, in the same cycle.
- Registers update on the rising edge of `clock`.
- Reset (async, any time including mid-wait or with a discard pending) clears `discard_pending`, `wait_cnt` and `stall_cycles` to 0. All outputs read 0 while `reset`=1 with inputs idle.
- Load-use costs exactly 1 stall cycle. Type2-after-load costs 2 (EX then MEM).
- Wait with ack on cycle N: stalls are asserted cycles 0..N-1 and drop in cycle N.
- `mem_timeout` is asserted in the `MEM_TIMEOUT`-th consecutive wait cycle.

## Test plan
- Load-use: `rs1_id`=5, `rs1_used_id`=1, Type1, `rd_ex`=5, `reg_we_ex`=1, `mem_rd_en_ex`=1 -> `stall_if`=`stall_id`=`flush_ex`=1 for 1 cycle. The same stimulus with `rd_ex`=0 -> no stall.
- Type2 branch: `rs2_id`=7 after an ALU op with `rd_ex`=7 -> stall. With `rs1_id`=7 and `zicsr_ex`=1 -> no stall. Type2 with `rd_mem`=7 and `mem_rd_en_mem`=1 -> stall.
- Memory wait: `data_mem_req_mem`=1, ack on the 3rd cycle, with `trap_mem`=1 and `pc_redirect_id`=1 also asserted -> all stalls plus `bubble_wb` for 2 cycles, no flushes. In the ack cycle, `flush_id`/`flush_ex`/`flush_mem`=1.
- Discard: `pc_redirect_id`=1 with `fetch_busy`=1, then `fetch_valid` 2 cycles later -> `discard_fetch`=1 only in that cycle. The next `fetch_valid` -> 0.
- Timeout: with `MEM_TIMEOUT`=4, hold `mem_wait` for 10 cycles -> `mem_timeout` high only in the 4th cycle. Assert `reset` mid-wait -> counters return to 0 immediately.
- Counter: force `stall_cycles` near saturation with `STALL_CNT_WIDTH`=4 and 20 stall cycles -> value reaches 15 and holds.
